// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and helpers for the load/store unit: RV32I
//               width/sign codes, FSM state type and access legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // RV32I funct3 width/sign codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  // True when the access must not reach memory: either the funct3 code is not
  // defined for this direction, or the address is not naturally aligned.
  function automatic logic access_fault(input logic       is_store,
                                        input logic [2:0] f3,
                                        input logic [1:0] byte_off);
    logic illegal;
    logic misaligned;
    if (is_store) begin
      illegal = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
    end else begin
      illegal = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                  (f3 == F3_BU) || (f3 == F3_HU));
    end
    misaligned = (((f3 == F3_H) || (f3 == F3_HU)) && byte_off[0]) ||
                 ((f3 == F3_W) && (byte_off != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/load_store_unit_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Selects the addressed byte/halfword lane of a raw memory word
//               and sign- or zero-extends it to the full datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            byte_off,
  input  logic [DATA_WIDTH-1:0] raw,
  output logic [DATA_WIDTH-1:0] result
);

  logic [DATA_WIDTH-1:0] w_lane;

  // Bring the addressed lane down to bit 0; upper bits are discarded below.
  assign w_lane = raw >> {byte_off, 3'b000};

  // Width selection with sign or zero extension; undefined codes return zero.
  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = {{(DATA_WIDTH-8){w_lane[7]}},   w_lane[7:0]};
      F3_H:    result = {{(DATA_WIDTH-16){w_lane[15]}}, w_lane[15:0]};
      F3_W:    result = w_lane;
      F3_BU:   result = {{(DATA_WIDTH-8){1'b0}},        w_lane[7:0]};
      F3_HU:   result = {{(DATA_WIDTH-16){1'b0}},       w_lane[15:0]};
      default: result = '0;
    endcase
  end

endmodule : load_extend
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory-access stage. Accepts one load/store at a time, runs a
//               request/grant/response handshake with data memory, returns
//               extended load data and flags illegal or misaligned accesses
//               without issuing any memory traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  fault,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);

  lsu_state_t            r_state;
  logic                  r_we;
  logic [2:0]            r_f3;
  logic [1:0]            r_off;

  logic                  w_fault;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_ext;

  assign req_ready = (r_state == IDLE);
  // Stall drops in RESP so the core advances in the same cycle as rsp_valid.
  assign stall     = ((r_state == IDLE) && req_valid) ||
                     (r_state == REQ) || (r_state == WAIT_R);

  assign w_fault   = access_fault(mem_write, funct3, addr[1:0]);

  // Byte enables from the incoming request; funct3[1:0] encodes the width.
  always_comb begin
    w_be = 4'b0000;
    case (funct3[1:0])
      2'b00:   w_be = 4'b0001 << addr[1:0];
      2'b01:   w_be = 4'b0011 << addr[1:0];
      default: w_be = 4'b1111;
    endcase
  end

  // Store data replicated to every lane so memory can just apply the enables.
  always_comb begin
    w_wdata = wdata;
    case (funct3[1:0])
      2'b00:   w_wdata = {4{wdata[7:0]}};
      2'b01:   w_wdata = {2{wdata[15:0]}};
      default: w_wdata = wdata;
    endcase
  end

  // Extension works from the captured request, since addr/funct3 inputs
  // belong to the next instruction by the time the response arrives.
  load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extend (
    .funct3  (r_f3),
    .byte_off(r_off),
    .raw     (dmem_rdata),
    .result  (w_ext)
  );

  // Transaction FSM; all memory-side and response outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_f3       <= 3'b000;
      r_off      <= 2'b00;
      rsp_valid  <= 1'b0;
      rdata      <= '0;
      fault      <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'b0000;
      dmem_wdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we  <= mem_write;
            r_f3  <= funct3;
            r_off <= addr[1:0];
            rdata <= '0;
            fault <= w_fault;
            if (w_fault) begin
              r_state   <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              r_state    <= REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= {addr[DATA_WIDTH-1:2], 2'b00};
              dmem_be    <= w_be;
              dmem_wdata <= w_wdata;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (r_we) begin
              r_state   <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              r_state <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (dmem_rvalid) begin
            rdata     <= w_ext;
            r_state   <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed scoreboard bench for load_store_unit. Stimulus pushes
//               the expected response; a monitor pops it on rsp_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rdata      (rdata),
    .fault      (fault),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_gnt   (dmem_gnt),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata (dmem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rsp_valid pulse must match the oldest outstanding expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata",   rdata, e.rdata);
          check("rsp_fault",   {31'b0, fault}, {31'b0, e.fault});
          check("rsp_latency", cyc, e.cyc);
          check("rsp_stall",   {31'b0, stall}, 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // Present a request in an IDLE cycle and queue its expected response
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int lat, input logic [31:0] erd,
                       input logic ef, input bit push);
    req_valid = 1'b1;
    mem_write = we;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    if (push) begin
      exp_t e;
      e.rdata = erd;
      e.fault = ef;
      e.cyc   = cyc + lat;
      exp_q.push_back(e);
    end
    @(negedge clk);
    check("accept_ready", {31'b0, req_ready}, 32'd1);
    check("accept_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Play the memory side after acceptance, checking request fields every cycle
  task automatic complete(input logic is_fault, input logic we, input logic [31:0] eaddr,
                          input logic [3:0] ebe, input logic [31:0] ewd,
                          input int gd, input int rd, input logic [31:0] raw);
    if (is_fault) begin
      @(negedge clk);
      check("fault_no_dmem_req", {31'b0, dmem_req}, 32'd0);
      @(posedge clk); #1;
    end else begin
      dmem_gnt = (gd == 0);
      for (int i = 0; i <= gd; i++) begin
        @(negedge clk);
        check("req_dmem_req", {31'b0, dmem_req}, 32'd1);
        check("req_dmem_we",  {31'b0, dmem_we}, {31'b0, we});
        check("req_addr",     dmem_addr, eaddr);
        check("req_be",       {28'b0, dmem_be}, {28'b0, ebe});
        check("req_wdata",    dmem_wdata, ewd);
        check("req_stall",    {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        dmem_gnt = (i + 1 == gd);
      end
      dmem_gnt = 1'b0;
      if (!we) begin
        dmem_rdata  = raw;
        dmem_rvalid = (rd == 0);
        for (int i = 0; i <= rd; i++) begin
          @(negedge clk);
          check("waitr_stall", {31'b0, stall}, 32'd1);
          check("waitr_no_req", {31'b0, dmem_req}, 32'd0);
          @(posedge clk); #1;
          dmem_rvalid = (i + 1 == rd);
        end
        dmem_rvalid = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] raw,
                         input int gd, input int rd, input logic [31:0] erd,
                         input logic [31:0] eaddr, input logic [3:0] ebe);
    issue(1'b0, f3, a, 32'd0, 3 + gd + rd, erd, 1'b0, 1'b1);
    complete(1'b0, 1'b0, eaddr, ebe, 32'd0, gd, rd, raw);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input int gd, input logic [31:0] eaddr, input logic [3:0] ebe,
                          input logic [31:0] ewd);
    issue(1'b1, f3, a, wd, 2 + gd, 32'd0, 1'b0, 1'b1);
    complete(1'b0, 1'b1, eaddr, ebe, ewd, gd, 0, 32'd0);
  endtask

  task automatic do_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    issue(we, f3, a, 32'h5555_5555, 1, 32'd0, 1'b1, 1'b1);
    complete(1'b1, we, 32'd0, 4'd0, 32'd0, 0, 0, 32'd0);
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_stall"},     {31'b0, stall}, 32'd0);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_fault"},     {31'b0, fault}, 32'd0);
    check({tag, "_dmem_req"},  {31'b0, dmem_req}, 32'd0);
    check({tag, "_dmem_we"},   {31'b0, dmem_we}, 32'd0);
    check({tag, "_rdata"},     rdata, 32'd0);
    check({tag, "_dmem_addr"}, dmem_addr, 32'd0);
    check({tag, "_dmem_be"},   {28'b0, dmem_be}, 32'd0);
    check({tag, "_dmem_wdata"}, dmem_wdata, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin : stimulus
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    mem_write   = 1'b0;
    funct3      = 3'b000;
    addr        = 32'd0;
    wdata       = 32'd0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset("reset");

    // Spurious rvalid/gnt while idle must not change anything
    dmem_rvalid = 1'b1;
    dmem_gnt    = 1'b1;
    dmem_rdata  = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    dmem_gnt    = 1'b0;
    @(negedge clk);
    check("spurious_rdata",    rdata, 32'd0);
    check("spurious_ready",    {31'b0, req_ready}, 32'd1);
    check("spurious_dmem_req", {31'b0, dmem_req}, 32'd0);
    @(posedge clk); #1;

    // Loads
    do_load(F3_W,  32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111);
    do_load(F3_B,  32'h0000_0103, 32'h8011_2233, 0, 0, 32'hFFFF_FF80, 32'h0000_0100, 4'b1000);
    do_load(F3_BU, 32'h0000_0103, 32'h8011_2233, 0, 0, 32'h0000_0080, 32'h0000_0100, 4'b1000);
    do_load(F3_H,  32'h0000_0102, 32'h8011_2233, 0, 0, 32'hFFFF_8011, 32'h0000_0100, 4'b1100);
    do_load(F3_HU, 32'h0000_0102, 32'h8011_2233, 1, 0, 32'h0000_8011, 32'h0000_0100, 4'b1100);
    do_load(F3_B,  32'h0000_0101, 32'h8011_2233, 0, 2, 32'h0000_0022, 32'h0000_0100, 4'b0010);

    // Stores
    do_store(F3_B, 32'h0000_0201, 32'h0000_00A5, 3, 32'h0000_0200, 4'b0010, 32'hA5A5_A5A5);
    do_store(F3_H, 32'h0000_0202, 32'h1234_BEEF, 0, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF);
    do_store(F3_W, 32'h0000_0204, 32'hCAFE_F00D, 1, 32'h0000_0204, 4'b1111, 32'hCAFE_F00D);

    // Faults: no memory traffic, response one cycle after accept
    do_fault(1'b1, F3_W,   32'h0000_0102);
    do_fault(1'b0, 3'b011, 32'h0000_0100);
    do_fault(1'b0, F3_H,   32'h0000_0101);
    do_fault(1'b1, 3'b100, 32'h0000_0100);

    // req_valid held through RESP: next request waits for the following IDLE cycle
    issue(1'b0, F3_W, 32'h0000_0302, 32'd0, 1, 32'd0, 1'b1, 1'b1);
    req_valid = 1'b1;
    mem_write = 1'b0;
    funct3    = F3_W;
    addr      = 32'h0000_0300;
    wdata     = 32'd0;
    @(negedge clk);
    check("resp_not_ready", {31'b0, req_ready}, 32'd0);
    check("resp_no_stall",  {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    do_load(F3_W, 32'h0000_0300, 32'h0000_0001, 0, 0, 32'h0000_0001, 32'h0000_0300, 4'b1111);

    // Reset during WAIT_R abandons the load; late rvalid is ignored
    issue(1'b0, F3_W, 32'h0000_0400, 32'd0, 3, 32'd0, 1'b0, 1'b0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    check("abort_req", {31'b0, dmem_req}, 32'd1);
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check("abort_waitr_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    rst_n       = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_5678;
    @(negedge clk);
    check("abort_req_dropped", {31'b0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    check_reset("abort");

    repeat (2) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_load_store_unit
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage sitting directly downstream of the ALU/operand-mux stage: takes the ALU result as effective address and the second register operand as store data, runs a multi-cycle request/grant/response transaction with data memory, and returns aligned, sign- or zero-extended load data to writeback. Stalls the core while a transaction is outstanding and flags misaligned or illegal accesses without touching memory.

## Interface
- DATA_WIDTH, 32, datapath and address width; byte-lane logic is fixed to 4 lanes.
- clk  in  1  single clock, rising edge
- rst_n  in  1  one clock; reset is synchronous and active-low
- req_valid  in  1  core presents a load/store this cycle
- req_ready  out  1  unit idle and able to accept
- mem_write  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
- addr  in  DATA_WIDTH  effective address (ALU output)
- wdata  in  DATA_WIDTH  store data (register operand 2)
- stall  out  1  hold PC and pipeline registers
- rsp_valid  out  1  one-cycle pulse: transaction finished
- rdata  out  DATA_WIDTH  extended load data, valid with rsp_valid
- fault  out  1  misaligned/illegal access, valid with rsp_valid
- dmem_req  out  1  memory request
- dmem_we  out  1  memory write enable
- dmem_addr  out  DATA_WIDTH  word-aligned address {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  DATA_WIDTH  lane-replicated store data
- dmem_gnt  in  1  memory accepted request
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  DATA_WIDTH  raw memory word

## Operation
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE: req_ready=1. On req_valid, capture mem_write, funct3, addr, wdata. Legal access -> REQ; fault -> RESP with fault latched, no memory activity.
- Fault: H/HU with addr[0]=1; W with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3 other than 000/001/010.
- REQ: dmem_req=1, dmem_we=captured mem_write; hold all dmem_* stable until dmem_gnt. On gnt: store -> RESP, load -> WAIT_R.
- WAIT_R: on dmem_rvalid, register extended data into rdata -> RESP.
- RESP: rsp_valid=1 for exactly one cycle -> IDLE. Stores and faults return rdata=0.
- Byte enables: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<addr[1:0]; W -> 4'b1111. Applied to loads and stores.
- Store data: B replicates wdata[7:0] to all lanes, H replicates wdata[15:0], W passes through.
- Load extract: lane = dmem_rdata >> (8*addr[1:0]); B/H sign-extend bit 7/15, BU/HU zero-extend, W unchanged.
- dmem_rvalid outside WAIT_R and dmem_gnt outside REQ are ignored.

## Timing
- Reset (rst_n low at an edge): state IDLE; req_ready=1 after release; stall, rsp_valid, fault, dmem_req, dmem_we =0; rdata, dmem_addr, dmem_be, dmem_wdata =0. Mid-transaction reset abandons it; dmem_req drops at that edge, a late rvalid is ignored.
- stall = (IDLE & req_valid) | REQ | WAIT_R; low in RESP so core advances in the rsp_valid cycle.
- Minimum latency accept->rsp_valid: fault 1 cycle; store with gnt in first REQ cycle 2 cycles; load with gnt and rvalid one cycle later 3 cycles. Each extra gnt/rvalid wait adds one cycle, no upper bound.
- rdata, fault registered; stable only while rsp_valid=1.
- req_valid in RESP is not accepted; accepted in the following IDLE cycle.

## Structure
- Package lsu_pkg: funct3 width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), lsu_state_t enum.
- Sub-module load_extend: combinational lane select plus sign/zero extension (funct3, addr[1:0], raw word -> DATA_WIDTH result).
- Byte-enable and store replication stay inline.

## Test plan
- LW addr 0x100, gnt immediate, rvalid next cycle with 0xDEADBEEF -> dmem_addr 0x100, be 1111, rsp_valid 3 cycles after accept, rdata 0xDEADBEEF, stall high for 3 cycles.
- LB addr 0x103, rdata word 0x80112233 -> be 1000, rdata 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF8011.
- SB addr 0x201, wdata 0x000000A5, gnt delayed 3 cycles -> dmem_we 1, be 0010, dmem_wdata 0xA5A5A5A5 held stable, rsp_valid 5 cycles after accept, rdata 0.
- SW addr 0x102 -> no dmem_req, rsp_valid+fault 1 cycle after accept; load funct3 011 -> same.
- rst_n low during WAIT_R, rvalid arrives after release -> outputs at reset values, no rsp_valid, req_ready 1.
- Spurious rvalid in IDLE and back-to-back req_valid held through RESP -> ignored; second request accepted in cycle after RESP.
